// File: rtl/l0_cache_invalidate_sequencer.sv
// L0 cache write-port owner: merges normal writes with full-cache invalidate
// sweeps and single-line invalidates; normal writes always take the port.
module l0_cache_invalidate_sequencer #(
  parameter int XLEN            = 32,
  parameter int CacheIndexWidth = 7,
  parameter int CacheTagWidth   = 7
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush_all_req,
  input  logic                       i_inv_line_req,
  input  logic [CacheIndexWidth-1:0] i_inv_line_index,
  input  logic                       i_wc_write_enable,
  input  logic [XLEN/8-1:0]          i_wc_byte_write_enable,
  input  logic [CacheIndexWidth-1:0] i_wc_write_index,
  input  logic [XLEN-1:0]            i_wc_write_data,
  input  logic [CacheTagWidth-1:0]   i_wc_write_tag,
  input  logic [XLEN/8-1:0]          i_wc_write_valid,
  output logic                       o_cache_write_enable,
  output logic [XLEN/8-1:0]          o_cache_byte_write_enable,
  output logic [CacheIndexWidth-1:0] o_cache_write_index,
  output logic [XLEN-1:0]            o_cache_write_data,
  output logic [CacheTagWidth-1:0]   o_cache_write_tag,
  output logic [XLEN/8-1:0]          o_cache_write_valid,
  output logic                       o_stall_request,
  output logic                       o_busy,
  output logic                       o_flush_done,
  output logic                       o_inv_line_ack
);

  localparam int IDXW = CacheIndexWidth;
  localparam int TAGW = CacheTagWidth;
  localparam int BW   = XLEN / 8;

  typedef enum logic [1:0] {IDLE, DRAIN, SWEEP, DONE} state_t;

  state_t          state, state_next;
  logic [IDXW-1:0] sweep_idx, sweep_idx_next;
  logic            rerun, rerun_next;
  logic            stall_next;

  logic            wr_en;
  logic [BW-1:0]   wr_bwe;
  logic [IDXW-1:0] wr_idx;
  logic [XLEN-1:0] wr_data;
  logic [TAGW-1:0] wr_tag;
  logic [BW-1:0]   wr_valid;
  logic            done_pulse;
  logic            ack_pulse;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= DRAIN;
      sweep_idx       <= '0;
      rerun           <= 1'b0;
      o_stall_request <= 1'b1;
    end else begin
      state           <= state_next;
      sweep_idx       <= sweep_idx_next;
      rerun           <= rerun_next;
      o_stall_request <= stall_next;
    end
  end

  always_comb begin
    state_next     = state;
    sweep_idx_next = sweep_idx;
    rerun_next     = rerun;
    done_pulse     = 1'b0;
    ack_pulse      = 1'b0;
    // Normal write path is the default owner of the port in every state.
    wr_en    = i_wc_write_enable;
    wr_bwe   = i_wc_byte_write_enable;
    wr_idx   = i_wc_write_index;
    wr_data  = i_wc_write_data;
    wr_tag   = i_wc_write_tag;
    wr_valid = i_wc_write_valid;

    case (state)
      IDLE: begin
        if (i_flush_all_req) begin
          state_next = DRAIN;
        end else if (i_inv_line_req && !i_wc_write_enable) begin
          wr_en     = 1'b1;
          wr_bwe    = '1;
          wr_idx    = i_inv_line_index;
          wr_data   = '0;
          wr_tag    = '0;
          wr_valid  = '0;
          ack_pulse = 1'b1;
        end
      end
      DRAIN: begin
        if (i_flush_all_req) rerun_next = 1'b1;
        state_next = SWEEP;
      end
      SWEEP: begin
        if (i_flush_all_req) rerun_next = 1'b1;
        if (!i_wc_write_enable) begin
          wr_en    = 1'b1;
          wr_bwe   = '1;
          wr_idx   = sweep_idx;
          wr_data  = '0;
          wr_tag   = '0;
          wr_valid = '0;
          if (&sweep_idx) begin
            // A flush landing on the final index still earns a second pass.
            sweep_idx_next = '0;
            rerun_next     = 1'b0;
            if (!(rerun || i_flush_all_req)) state_next = DONE;
          end else begin
            sweep_idx_next = sweep_idx + IDXW'(1);
          end
        end
      end
      DONE: begin
        done_pulse = 1'b1;
        ack_pulse  = i_inv_line_req;
        state_next = i_flush_all_req ? DRAIN : IDLE;
      end
      default: state_next = DRAIN;
    endcase

    stall_next = (state_next != IDLE) ||
                 (state == IDLE && !i_flush_all_req && i_inv_line_req && i_wc_write_enable);
  end

  always_comb begin
    o_cache_write_enable      = wr_en && !i_rst;
    o_cache_byte_write_enable = i_rst ? '0 : wr_bwe;
    o_cache_write_index       = i_rst ? '0 : wr_idx;
    o_cache_write_data        = i_rst ? '0 : wr_data;
    o_cache_write_tag         = i_rst ? '0 : wr_tag;
    o_cache_write_valid       = i_rst ? '0 : wr_valid;
    o_busy                    = (state != IDLE) && !i_rst;
    o_flush_done              = done_pulse && !i_rst;
    o_inv_line_ack            = ack_pulse && !i_rst;
  end

endmodule

// File: tb/tb_l0_cache_invalidate_sequencer.sv
// Scenario bench for the L0 invalidate sequencer; cache-port writes are
// checked in order against a queue of expected writes.
module tb_l0_cache_invalidate_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_flush_all_req;
  logic        i_inv_line_req;
  logic [6:0]  i_inv_line_index;
  logic        i_wc_write_enable;
  logic [3:0]  i_wc_byte_write_enable;
  logic [6:0]  i_wc_write_index;
  logic [31:0] i_wc_write_data;
  logic [6:0]  i_wc_write_tag;
  logic [3:0]  i_wc_write_valid;
  logic        o_cache_write_enable;
  logic [3:0]  o_cache_byte_write_enable;
  logic [6:0]  o_cache_write_index;
  logic [31:0] o_cache_write_data;
  logic [6:0]  o_cache_write_tag;
  logic [3:0]  o_cache_write_valid;
  logic        o_stall_request;
  logic        o_busy;
  logic        o_flush_done;
  logic        o_inv_line_ack;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [6:0]  idx;
    logic [31:0] data;
    logic [6:0]  tag;
    logic [3:0]  valid;
    logic [3:0]  bwe;
  } wr_t;
  wr_t exp_q[$];

  always #5 i_clk = ~i_clk;

  l0_cache_invalidate_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_flush_all_req(i_flush_all_req),
    .i_inv_line_req(i_inv_line_req), .i_inv_line_index(i_inv_line_index),
    .i_wc_write_enable(i_wc_write_enable),
    .i_wc_byte_write_enable(i_wc_byte_write_enable),
    .i_wc_write_index(i_wc_write_index), .i_wc_write_data(i_wc_write_data),
    .i_wc_write_tag(i_wc_write_tag), .i_wc_write_valid(i_wc_write_valid),
    .o_cache_write_enable(o_cache_write_enable),
    .o_cache_byte_write_enable(o_cache_byte_write_enable),
    .o_cache_write_index(o_cache_write_index),
    .o_cache_write_data(o_cache_write_data),
    .o_cache_write_tag(o_cache_write_tag),
    .o_cache_write_valid(o_cache_write_valid),
    .o_stall_request(o_stall_request), .o_busy(o_busy),
    .o_flush_done(o_flush_done), .o_inv_line_ack(o_inv_line_ack)
  );

  function automatic void push_inv(input logic [6:0] idx);
    wr_t w;
    w.idx = idx; w.data = '0; w.tag = '0; w.valid = '0; w.bwe = 4'hF;
    exp_q.push_back(w);
  endfunction

  function automatic void push_wc(input logic [6:0] idx, input logic [31:0] data,
                                  input logic [6:0] tag, input logic [3:0] valid,
                                  input logic [3:0] bwe);
    wr_t w;
    w.idx = idx; w.data = data; w.tag = tag; w.valid = valid; w.bwe = bwe;
    exp_q.push_back(w);
  endfunction

  // Scoreboard: every cache write must match the oldest expected write.
  always @(negedge i_clk) begin
    if (o_cache_write_enable) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_unexpected: got idx=%0h data=%h tag=%0h valid=%0h bwe=%0h, expected no write",
                 o_cache_write_index, o_cache_write_data, o_cache_write_tag,
                 o_cache_write_valid, o_cache_byte_write_enable);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (o_cache_write_index !== e.idx || o_cache_write_data !== e.data ||
            o_cache_write_tag !== e.tag || o_cache_write_valid !== e.valid ||
            o_cache_byte_write_enable !== e.bwe) begin
          miscompares++;
          $display("FAIL scoreboard_write: got idx=%0h data=%h tag=%0h valid=%0h bwe=%0h, expected idx=%0h data=%h tag=%0h valid=%0h bwe=%0h",
                   o_cache_write_index, o_cache_write_data, o_cache_write_tag,
                   o_cache_write_valid, o_cache_byte_write_enable,
                   e.idx, e.data, e.tag, e.valid, e.bwe);
        end else begin
          $display("write idx=%0h data=%h tag=%0h valid=%0h bwe=%0h ok",
                   e.idx, e.data, e.tag, e.valid, e.bwe);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_flush_all_req = 0; i_inv_line_req = 0; i_inv_line_index = '0;
    i_wc_write_enable = 0; i_wc_byte_write_enable = '0; i_wc_write_index = '0;
    i_wc_write_data = '0; i_wc_write_tag = '0; i_wc_write_valid = '0;
  endtask

  task automatic test_reset();
    i_rst = 1;
    idle_inputs();
    i_wc_write_enable = 1; i_wc_write_index = 7'h11; i_wc_write_data = 32'hDEADBEEF;
    i_wc_byte_write_enable = 4'hF; i_wc_write_tag = 7'h5; i_wc_write_valid = 4'hF;
    repeat (2) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    vectors++;
    if ({o_cache_write_enable, o_cache_byte_write_enable, o_cache_write_index,
         o_cache_write_data, o_cache_write_tag, o_cache_write_valid,
         o_busy, o_flush_done, o_inv_line_ack} !== '0 || o_stall_request !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_outputs: we=%b data=%h busy=%b done=%b ack=%b stall=%b, expected all 0 with stall=1",
               o_cache_write_enable, o_cache_write_data, o_busy, o_flush_done,
               o_inv_line_ack, o_stall_request);
    end else $display("reset outputs ok");
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_full_sweep();
    int done_c = -1;
    for (int i = 0; i < 128; i++) push_inv(7'(i));
    i_rst = 0;
    for (int c = 0; c < 200 && done_c < 0; c++) begin
      @(negedge i_clk);
      if (c == 0) begin
        vectors++;
        if (o_busy !== 1'b1 || o_stall_request !== 1'b1 || o_cache_write_enable !== 1'b0) begin
          miscompares++;
          $display("FAIL drain_cycle: busy=%b stall=%b we=%b, expected 1 1 0",
                   o_busy, o_stall_request, o_cache_write_enable);
        end
      end
      if (o_flush_done) done_c = c;
      next_cycle();
    end
    vectors++;
    if (done_c != 129) begin
      miscompares++;
      $display("FAIL sweep_done_cycle: got %0d, expected 129", done_c);
    end else $display("post-reset sweep done at cycle %0d", done_c);
    @(negedge i_clk);
    vectors++;
    if (o_stall_request !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_after_done: stall=%b busy=%b, expected 0 0", o_stall_request, o_busy);
    end
    next_cycle();
  endtask

  task automatic test_sweep_pause();
    int done_c = -1;
    for (int i = 0; i < 5; i++) push_inv(7'(i));
    for (int k = 0; k < 3; k++) push_wc(7'd9, 32'hA5A5_0000 + 32'(k), 7'h33, 4'hF, 4'h3);
    for (int i = 5; i < 128; i++) push_inv(7'(i));
    for (int c = 0; c < 300 && done_c < 0; c++) begin
      i_flush_all_req = (c == 0);
      i_wc_write_enable = (c >= 7 && c < 10);
      i_wc_write_index = 7'd9; i_wc_write_tag = 7'h33;
      i_wc_write_valid = 4'hF; i_wc_byte_write_enable = 4'h3;
      i_wc_write_data = 32'hA5A5_0000 + 32'(c - 7);
      @(negedge i_clk);
      if (o_flush_done) done_c = c;
      next_cycle();
    end
    idle_inputs();
    vectors++;
    if (done_c != 133) begin
      miscompares++;
      $display("FAIL pause_done_cycle: got %0d, expected 133", done_c);
    end else $display("paused sweep done at cycle %0d", done_c);
  endtask

  task automatic test_inv_line();
    push_inv(7'h22);
    i_inv_line_req = 1; i_inv_line_index = 7'h22;
    @(negedge i_clk);
    vectors++;
    if (o_inv_line_ack !== 1'b1 || o_stall_request !== 1'b0) begin
      miscompares++;
      $display("FAIL inv_line_ack: ack=%b stall=%b, expected 1 0", o_inv_line_ack, o_stall_request);
    end else $display("line invalidate 0x22 acked");
    next_cycle();
    idle_inputs();
    @(negedge i_clk);
    vectors++;
    if (o_stall_request !== 1'b0) begin
      miscompares++;
      $display("FAIL inv_line_stall: got %b, expected 0", o_stall_request);
    end
    next_cycle();
  endtask

  task automatic test_inv_deferred();
    logic exp_ack [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic exp_stall [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    push_wc(7'h22, 32'h1111_2222, 7'h44, 4'hF, 4'hF);
    push_wc(7'h22, 32'h3333_4444, 7'h44, 4'hC, 4'h5);
    push_inv(7'h22);
    for (int c = 0; c < 4; c++) begin
      i_inv_line_req = (c < 3); i_inv_line_index = 7'h22;
      i_wc_write_enable = (c < 2); i_wc_write_index = 7'h22; i_wc_write_tag = 7'h44;
      i_wc_write_data = (c == 0) ? 32'h1111_2222 : 32'h3333_4444;
      i_wc_write_valid = (c == 0) ? 4'hF : 4'hC;
      i_wc_byte_write_enable = (c == 0) ? 4'hF : 4'h5;
      @(negedge i_clk);
      vectors++;
      if (o_inv_line_ack !== exp_ack[c] || o_stall_request !== exp_stall[c]) begin
        miscompares++;
        $display("FAIL deferred_c%0d: ack=%b stall=%b, expected ack=%b stall=%b",
                 c, o_inv_line_ack, o_stall_request, exp_ack[c], exp_stall[c]);
      end else $display("deferred line cycle %0d ack=%b stall=%b", c, exp_ack[c], exp_stall[c]);
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_rerun();
    int dones = 0;
    int done_c = -1;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 128; i++) push_inv(7'(i));
    for (int c = 0; c < 266; c++) begin
      i_flush_all_req = (c == 0 || c == 102);
      @(negedge i_clk);
      if (o_flush_done) begin dones++; done_c = c; end
      next_cycle();
    end
    idle_inputs();
    vectors++;
    if (dones != 1 || done_c != 258) begin
      miscompares++;
      $display("FAIL rerun_done: count=%0d cycle=%0d, expected count=1 cycle=258", dones, done_c);
    end else $display("rerun sweep done once at cycle %0d", done_c);
  endtask

  task automatic test_flush_vs_line();
    int done_c = -1;
    logic ack_at_done = 0;
    logic early_ack = 0;
    for (int i = 0; i < 128; i++) push_inv(7'(i));
    i_inv_line_req = 1; i_inv_line_index = 7'h7F;
    for (int c = 0; c < 200 && done_c < 0; c++) begin
      i_flush_all_req = (c == 0);
      @(negedge i_clk);
      if (o_flush_done) begin done_c = c; ack_at_done = o_inv_line_ack; end
      else if (o_inv_line_ack) early_ack = 1;
      next_cycle();
    end
    idle_inputs();
    vectors++;
    if (done_c != 130 || ack_at_done !== 1'b1 || early_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_vs_line: done=%0d ack_at_done=%b early_ack=%b, expected 130 1 0",
               done_c, ack_at_done, early_ack);
    end else $display("flush outranked line request, ack with done at %0d", done_c);
  endtask

  task automatic test_reset_mid_sweep();
    int done_c = -1;
    for (int i = 0; i < 60; i++) push_inv(7'(i));
    for (int c = 0; c < 62; c++) begin
      i_flush_all_req = (c == 0);
      next_cycle();
    end
    idle_inputs();
    i_rst = 1;
    i_wc_write_enable = 1; i_wc_write_index = 7'h3C; i_wc_write_data = 32'hCAFE_F00D;
    for (int r = 0; r < 2; r++) begin
      @(negedge i_clk);
      vectors++;
      if (o_cache_write_enable !== 1'b0 || o_cache_write_data !== '0 || o_busy !== 1'b0 ||
          o_flush_done !== 1'b0 || o_stall_request !== 1'b1) begin
        miscompares++;
        $display("FAIL mid_reset_r%0d: we=%b data=%h busy=%b done=%b stall=%b, expected 0 0 0 0 1",
                 r, o_cache_write_enable, o_cache_write_data, o_busy, o_flush_done, o_stall_request);
      end
      next_cycle();
    end
    idle_inputs();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reset_queue: %0d writes outstanding, expected 0", exp_q.size());
    end
    for (int i = 0; i < 128; i++) push_inv(7'(i));
    i_rst = 0;
    for (int c = 0; c < 200 && done_c < 0; c++) begin
      @(negedge i_clk);
      if (o_flush_done) done_c = c;
      next_cycle();
    end
    vectors++;
    if (done_c != 129) begin
      miscompares++;
      $display("FAIL mid_reset_done: got %0d, expected 129", done_c);
    end else $display("restarted sweep done at cycle %0d", done_c);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      logic [31:0] d = $urandom;
      logic [6:0]  ix = 7'($urandom_range(0, 127));
      push_wc(ix, d, 7'(k), 4'(k), 4'hF ^ 4'(k));
      i_wc_write_enable = 1; i_wc_write_index = ix; i_wc_write_data = d;
      i_wc_write_tag = 7'(k); i_wc_write_valid = 4'(k); i_wc_byte_write_enable = 4'hF ^ 4'(k);
      @(negedge i_clk);
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_sweep_pause();
    test_inv_line();
    test_inv_deferred();
    test_back_to_back();
    test_rerun();
    test_flush_vs_line();
    test_reset_mid_sweep();
    @(negedge i_clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_queue: %0d writes never seen, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
